// File: rtl/isp_bnr_ctrl_if.sv
// ---------------------------------------------------------------------------
// isp_bnr_ctrl_if
// Host configuration channel for the Bayer noise-reduction controller.
//   cfg_valid  host -> ctrl  configuration word valid
//   cfg_ready  ctrl -> host  controller can take a configuration word
//   cfg_auto   host -> ctrl  1 = level follows sensor gain, 0 = manual
//   cfg_level  host -> ctrl  manual NR level (values above 4 clamp to 4)
// Modports: master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface isp_bnr_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_auto;
    logic [3:0] cfg_level;

    modport master (
        output cfg_valid,
        output cfg_auto,
        output cfg_level,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_auto,
        input  cfg_level,
        output cfg_ready
    );
endinterface

// File: rtl/isp_bnr_ctrl.sv
// ---------------------------------------------------------------------------
// isp_bnr_ctrl
// Frame-synchronous controller owning the NR level (0..4) of the Bayer
// noise-reduction filter. Host configuration is buffered in a one-deep
// pending register and applied only at a rising in_vsync. In auto mode the
// level moves by at most one step per frame, driven by the sensor gain with
// a downward hysteresis margin, so the kernel never changes mid-frame.
//
// Ports:
//   pclk       pixel clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   in_vsync   frame sync, rising edge marks a frame boundary
//   gain       sensor gain, sampled at boundaries only
//   cfg        configuration handshake (isp_bnr_ctrl_if.slave)
//   nr_level   level to the BNR filter, constant within a frame
//   level_chg  one-cycle pulse when nr_level changes
//   auto_mode  currently applied mode (1 = auto)
//   frame_cnt  boundaries seen since reset, wraps at 16 bits
// ---------------------------------------------------------------------------
module isp_bnr_ctrl #(
    parameter int GAIN_BITS = 8,
    parameter int TH1       = 16,
    parameter int TH2       = 32,
    parameter int TH3       = 64,
    parameter int TH4       = 128,
    parameter int HYST      = 4
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 in_vsync,
    input  logic [GAIN_BITS-1:0] gain,
    isp_bnr_ctrl_if.slave        cfg,
    output logic [3:0]           nr_level,
    output logic                 level_chg,
    output logic                 auto_mode,
    output logic [15:0]          frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME,
        S_EVAL
    } state_t;

    // Thresholds and margin widened by one bit so gain + HYST cannot overflow.
    localparam logic [GAIN_BITS:0] C_TH1  = TH1[GAIN_BITS:0];
    localparam logic [GAIN_BITS:0] C_TH2  = TH2[GAIN_BITS:0];
    localparam logic [GAIN_BITS:0] C_TH3  = TH3[GAIN_BITS:0];
    localparam logic [GAIN_BITS:0] C_TH4  = TH4[GAIN_BITS:0];
    localparam logic [GAIN_BITS:0] C_HYST = HYST[GAIN_BITS:0];

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_vs_d;
    logic                   r_low_seen;
    logic                   r_pend_valid;
    logic                   r_pend_auto;
    logic [3:0]             r_pend_level;
    logic                   r_work_auto;
    logic [3:0]             r_work_level;
    logic [GAIN_BITS-1:0]   r_g_s;
    logic [15:0]            r_frame_cnt;
    logic [3:0]             r_nr_level;
    logic                   r_level_chg;

    logic                   w_edge;
    logic                   w_boundary;
    logic                   w_eval;
    logic                   w_cfg_ready;
    logic                   w_accept;
    logic [3:0]             w_cfg_level_clamped;
    logic [GAIN_BITS:0]     w_gs_ext;
    logic [GAIN_BITS:0]     w_gs_hyst;
    logic [GAIN_BITS:0]     w_th_cur;
    logic [2:0]             w_raw;
    logic [3:0]             w_next_level;

    // r_low_seen blocks a false edge when in_vsync is already high as reset
    // releases: a boundary needs in_vsync to have been sampled low first.
    assign w_edge = in_vsync & ~r_vs_d & r_low_seen;

    assign w_cfg_level_clamped = (cfg.cfg_level > 4'd4) ? 4'd4 : cfg.cfg_level;
    assign w_accept            = cfg.cfg_valid & w_cfg_ready;
    assign cfg.cfg_ready       = w_cfg_ready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_boundary  = 1'b0;
        w_eval      = 1'b0;
        w_cfg_ready = 1'b0;
        unique case (r_state)
            S_IDLE, S_FRAME: begin
                w_cfg_ready = ~r_pend_valid;
                if (w_edge) begin
                    w_boundary  = 1'b1;
                    w_state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                w_eval      = 1'b1;
                w_state_nxt = S_FRAME;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------- next-level decision
    assign w_gs_ext  = {1'b0, r_g_s};
    assign w_gs_hyst = w_gs_ext + C_HYST;
    assign w_raw     = 3'(w_gs_ext >= C_TH1) + 3'(w_gs_ext >= C_TH2)
                     + 3'(w_gs_ext >= C_TH3) + 3'(w_gs_ext >= C_TH4);

    // Threshold of the current level, used for the downward step test.
    always_comb begin
        w_th_cur = '0;
        unique case (r_nr_level)
            4'd1:    w_th_cur = C_TH1;
            4'd2:    w_th_cur = C_TH2;
            4'd3:    w_th_cur = C_TH3;
            4'd4:    w_th_cur = C_TH4;
            default: w_th_cur = '0;
        endcase
    end

    always_comb begin
        w_next_level = r_nr_level;
        if (!r_work_auto) begin
            w_next_level = r_work_level;
        end else if ({1'b0, w_raw} > r_nr_level) begin
            w_next_level = r_nr_level + 4'd1;
        end else if ((r_nr_level != 4'd0) && (w_gs_hyst < w_th_cur)) begin
            w_next_level = r_nr_level - 4'd1;
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_vs_d       <= 1'b0;
            r_low_seen   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_auto  <= 1'b0;
            r_pend_level <= '0;
            r_work_auto  <= 1'b0;
            r_work_level <= '0;
            r_g_s        <= '0;
            r_frame_cnt  <= '0;
            r_nr_level   <= '0;
            r_level_chg  <= 1'b0;
        end else begin
            r_vs_d      <= in_vsync;
            r_level_chg <= 1'b0;
            if (!in_vsync) begin
                r_low_seen <= 1'b1;
            end

            if (w_boundary) begin
                r_g_s       <= gain;
                r_frame_cnt <= r_frame_cnt + 16'd1;
                if (r_pend_valid) begin
                    r_work_auto  <= r_pend_auto;
                    r_work_level <= r_pend_level;
                end
            end

            // An accept requires an empty slot, so it never collides with an
            // entry being consumed; a word accepted on the boundary cycle
            // stays pending for the next boundary.
            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_auto  <= cfg.cfg_auto;
                r_pend_level <= w_cfg_level_clamped;
            end else if (w_boundary) begin
                r_pend_valid <= 1'b0;
            end

            if (w_eval) begin
                r_nr_level  <= w_next_level;
                r_level_chg <= (w_next_level != r_nr_level);
            end
        end
    end

    assign nr_level  = r_nr_level;
    assign level_chg = r_level_chg;
    assign auto_mode = r_work_auto;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_isp_bnr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_isp_bnr_ctrl
// Self-checking bench for isp_bnr_ctrl. A frame-level reference model keeps
// the applied mode, level, pending configuration and boundary count, and
// each scenario task compares the DUT against it.
// ---------------------------------------------------------------------------
module tb_isp_bnr_ctrl;

    logic        pclk = 1'b0;
    logic        rst;
    logic        in_vsync;
    logic [7:0]  gain;
    logic [3:0]  nr_level;
    logic        level_chg;
    logic        auto_mode;
    logic [15:0] frame_cnt;

    isp_bnr_ctrl_if cfg_if ();

    isp_bnr_ctrl #(
        .GAIN_BITS (8),
        .TH1       (16),
        .TH2       (32),
        .TH3       (64),
        .TH4       (128),
        .HYST      (4)
    ) dut (
        .pclk      (pclk),
        .rst       (rst),
        .in_vsync  (in_vsync),
        .gain      (gain),
        .cfg       (cfg_if),
        .nr_level  (nr_level),
        .level_chg (level_chg),
        .auto_mode (auto_mode),
        .frame_cnt (frame_cnt)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    int TH[5] = '{0, 16, 32, 64, 128};
    localparam int HYST = 4;

    // Reference model state
    int m_level;
    int m_auto;
    int m_work;
    int m_fc;
    int m_pv;
    int m_pa;
    int m_pl;

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic model_reset;
        m_level = 0; m_auto = 0; m_work = 0; m_fc = 0;
        m_pv = 0; m_pa = 0; m_pl = 0;
    endtask

    function automatic int clampl(input int l);
        return (l > 4) ? 4 : l;
    endfunction

    task automatic model_boundary(input int g, output int exp_level, output int exp_chg);
        int raw;
        int nxt;
        if (m_pv != 0) begin
            m_auto = m_pa;
            m_work = m_pl;
            m_pv   = 0;
        end
        m_fc = (m_fc + 1) % 65536;
        if (m_auto == 0) begin
            nxt = m_work;
        end else begin
            raw = 0;
            for (int k = 1; k <= 4; k++) if (g >= TH[k]) raw++;
            if (raw > m_level)                                  nxt = m_level + 1;
            else if (m_level > 0 && (g + HYST) < TH[m_level])   nxt = m_level - 1;
            else                                                nxt = m_level;
        end
        exp_chg   = (nxt != m_level) ? 1 : 0;
        m_level   = nxt;
        exp_level = nxt;
    endtask

    // Present a config word and hold it until accepted (bounded wait).
    task automatic send_cfg(input int a, input int l, input string nm);
        int waited;
        logic [3:0] lv;
        lv = 4'(l);
        waited = 0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_auto  = 1'(a);
        cfg_if.cfg_level = lv;
        while (cfg_if.cfg_ready !== 1'b1 && waited < 20) begin
            tick;
            waited++;
        end
        total++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s accept_timeout cfg_ready=%b expected=1", nm, cfg_if.cfg_ready);
            cfg_if.cfg_valid = 1'b0;
        end else begin
            tick;
            cfg_if.cfg_valid = 1'b0;
            m_pv = 1; m_pa = a; m_pl = clampl(l);
            total++;
            if (cfg_if.cfg_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s ready_after_accept got=%b expected=0", nm, cfg_if.cfg_ready);
            end
        end
    endtask

    // One frame boundary with the given gain, checked through n+1 .. n+3.
    task automatic do_frame(input int g, input string nm);
        int el;
        int ec;
        int old;
        old = m_level;
        in_vsync = 1'b1;
        gain     = 8'(g);
        tick;                               // edge sampled, now in eval cycle
        gain = 8'($urandom_range(0, 255));  // gain is only sampled at the edge
        model_boundary(g, el, ec);
        total++;
        if (frame_cnt !== 16'(m_fc)) begin
            bad++; $display("FAIL %s frame_cnt got=%0d expected=%0d", nm, frame_cnt, m_fc);
        end
        total++;
        if (auto_mode !== 1'(m_auto)) begin
            bad++; $display("FAIL %s auto_mode got=%b expected=%0d", nm, auto_mode, m_auto);
        end
        total++;
        if (nr_level !== 4'(old)) begin
            bad++; $display("FAIL %s level_during_eval got=%0d expected=%0d", nm, nr_level, old);
        end
        total++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            bad++; $display("FAIL %s ready_during_eval got=%b expected=0", nm, cfg_if.cfg_ready);
        end
        tick;
        total++;
        if (nr_level !== 4'(el)) begin
            bad++; $display("FAIL %s nr_level got=%0d expected=%0d", nm, nr_level, el);
        end
        total++;
        if (level_chg !== 1'(ec)) begin
            bad++; $display("FAIL %s level_chg got=%b expected=%0d", nm, level_chg, ec);
        end
        in_vsync = 1'b0;
        tick;
        total++;
        if (level_chg !== 1'b0 || nr_level !== 4'(el)) begin
            bad++;
            $display("FAIL %s after_pulse chg=%b lvl=%0d expected chg=0 lvl=%0d",
                     nm, level_chg, nr_level, el);
        end
        tick;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_vsync = 1'b1;            // high through reset: must not count as an edge
        gain = 8'd0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_auto  = 1'b0;
        cfg_if.cfg_level = 4'd0;
        repeat (3) tick;
        rst = 1'b0;
        model_reset;
        tick;
        total++;
        if (nr_level !== 4'd0 || level_chg !== 1'b0 || auto_mode !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs lvl=%0d chg=%b auto=%b expected 0/0/0",
                     nr_level, level_chg, auto_mode);
        end
        total++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b expected=1", cfg_if.cfg_ready);
        end
        tick;
        tick;
        total++;
        if (frame_cnt !== 16'd0) begin
            bad++; $display("FAIL reset_no_edge frame_cnt got=%0d expected=0", frame_cnt);
        end
        in_vsync = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_manual;
        send_cfg(0, 3, "manual3");
        do_frame(50, "manual3");
    endtask

    task automatic test_clamp;
        send_cfg(0, 9, "clamp9");
        do_frame(10, "clamp9");
        do_frame(10, "clamp_hold");
        send_cfg(0, 1, "manual_jump");
        do_frame(10, "manual_jump");
    endtask

    task automatic test_auto_ramp;
        send_cfg(0, 0, "to_zero");
        do_frame(200, "to_zero");
        send_cfg(1, 0, "auto_on");
        for (int i = 0; i < 6; i++) do_frame(200, "ramp");
    endtask

    task automatic test_hyst;
        do_frame(40, "down_a");
        do_frame(40, "down_b");
        do_frame(30, "hyst_hold");
        do_frame(27, "hyst_drop");
        do_frame(20, "hyst_hold1");
    endtask

    task automatic test_back_to_back;
        int el;
        int ec;
        send_cfg(0, 2, "b2b_first");
        // Second word presented before and held across the boundary.
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_auto  = 1'b0;
        cfg_if.cfg_level = 4'd1;
        in_vsync = 1'b1;
        gain = 8'd99;
        tick;
        model_boundary(99, el, ec);
        total++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_ready_eval got=%b expected=0", cfg_if.cfg_ready);
        end
        tick;
        total++;
        if (nr_level !== 4'(el) || level_chg !== 1'(ec)) begin
            bad++;
            $display("FAIL b2b_first_applied lvl=%0d chg=%b expected lvl=%0d chg=%0d",
                     nr_level, level_chg, el, ec);
        end
        total++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_ready_rise got=%b expected=1", cfg_if.cfg_ready);
        end
        tick;                       // second word accepted on this edge
        cfg_if.cfg_valid = 1'b0;
        m_pv = 1; m_pa = 0; m_pl = 1;
        total++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_second_pending got=%b expected=0", cfg_if.cfg_ready);
        end
        in_vsync = 1'b0;
        tick;
        tick;
        do_frame(99, "b2b_second");

        // Word accepted in the boundary cycle waits for the following frame.
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_auto  = 1'b0;
        cfg_if.cfg_level = 4'd4;
        in_vsync = 1'b1;
        gain = 8'd5;
        tick;
        cfg_if.cfg_valid = 1'b0;
        model_boundary(5, el, ec);
        m_pv = 1; m_pa = 0; m_pl = 4;
        tick;
        total++;
        if (nr_level !== 4'(el) || level_chg !== 1'(ec)) begin
            bad++;
            $display("FAIL edge_cfg_deferred lvl=%0d chg=%b expected lvl=%0d chg=%0d",
                     nr_level, level_chg, el, ec);
        end
        in_vsync = 1'b0;
        tick;
        total++;
        if (cfg_if.cfg_ready !== 1'b0) begin
            bad++; $display("FAIL edge_cfg_pending got=%b expected=0", cfg_if.cfg_ready);
        end
        tick;
        do_frame(5, "edge_cfg_applied");
    endtask

    task automatic test_wrap;
        @(negedge pclk);
        force dut.r_frame_cnt = 16'hFFFE;
        @(posedge pclk);
        #1;
        release dut.r_frame_cnt;
        m_fc = 16'hFFFE;
        tick;
        do_frame(70, "wrap_ffff");
        do_frame(70, "wrap_zero");
    endtask

    task automatic test_mid_reset;
        send_cfg(1, 2, "pre_reset");
        tick;
        rst = 1'b1;
        tick;
        model_reset;
        total++;
        if (nr_level !== 4'd0 || level_chg !== 1'b0 || auto_mode !== 1'b0 || frame_cnt !== 16'd0) begin
            bad++;
            $display("FAIL midrst_outputs lvl=%0d chg=%b auto=%b fc=%0d expected all 0",
                     nr_level, level_chg, auto_mode, frame_cnt);
        end
        total++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_ready got=%b expected=1", cfg_if.cfg_ready);
        end
        rst = 1'b0;
        tick;
        do_frame(200, "midrst_discard");
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                send_cfg(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), "rand_cfg");
            repeat ($urandom_range(0, 3)) tick;
            do_frame(int'($urandom_range(0, 255)), "rand_frame");
        end
    endtask

    initial begin
        test_reset;
        test_manual;
        test_clamp;
        test_auto_ramp;
        test_hyst;
        test_back_to_back;
        test_wrap;
        test_mid_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
